// File: rtl/apb_pkg.sv
// Shared types and widths for the APB4 requester and its watchdog.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam int APB_STRB_W = 4;
    localparam int APB_PROT_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    // Request fields latched at accept and driven unchanged onto the bus.
    typedef struct packed {
        logic [APB_ADDR_W-1:0] addr;
        logic                  write;
        logic [APB_DATA_W-1:0] wdata;
        logic [APB_STRB_W-1:0] strb;
        logic [APB_PROT_W-1:0] prot;
    } apb_req_t;

endpackage

// File: rtl/apb_watchdog.sv
// Saturating ACCESS-phase cycle counter; flags the cycle in which the TIMEOUT-th
// un-ready cycle is being spent. TIMEOUT=0 disables it.
module apb_watchdog
    import apb_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT : 0);
    localparam bit ACTIVE = (TIMEOUT > 0);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (ACTIVE && enable && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Expiry is reported combinationally so the FSM leaves ACCESS after exactly TIMEOUT cycles.
    assign expired = ACTIVE && enable && !clear && (cnt_q >= LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/apb_requester.sv
// APB4 requester: one valid/ready request becomes one APB transfer, whose result
// is returned on a valid/ready response channel; a watchdog aborts hung transfers.
module apb_requester
    import apb_pkg::*;
#(
    parameter int TIMEOUT     = 1024,
    parameter int CHECK_ALIGN = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [APB_ADDR_W-1:0] req_addr,
    input  logic                  req_write,
    input  logic [APB_DATA_W-1:0] req_wdata,
    input  logic [APB_STRB_W-1:0] req_wstrb,
    input  logic [APB_PROT_W-1:0] req_prot,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [APB_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [APB_ADDR_W-1:0] paddr,
    output logic                  psel,
    output logic                  penable,
    output logic [APB_PROT_W-1:0] pprot,
    output logic                  pwrite,
    output logic [APB_DATA_W-1:0] pwdata,
    output logic [APB_STRB_W-1:0] pstrb,
    input  logic                  pready,
    input  logic [APB_DATA_W-1:0] prdata,
    input  logic                  pslverr
);

    apb_state_e state_q, state_d;
    apb_req_t   req_q, req_d;
    logic       psel_q, psel_d;
    logic       penable_q, penable_d;
    logic       req_ready_q, req_ready_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [APB_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic       rsp_err_q, rsp_err_d;
    logic       rsp_timeout_q, rsp_timeout_d;

    logic wd_clear, wd_enable, wd_expired;
    logic misaligned;

    assign wd_clear   = (state_q != ACCESS);
    assign wd_enable  = (state_q == ACCESS) && !pready;
    assign misaligned = (CHECK_ALIGN != 0) && (req_addr[1:0] != 2'b00);

    apb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expired(wd_expired)
    );

    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        req_ready_d   = req_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d.addr  = req_addr;
                    req_d.write = req_write;
                    req_d.wdata = req_wdata;
                    req_d.strb  = req_write ? req_wstrb : '0;
                    req_d.prot  = req_prot;
                    req_ready_d = 1'b0;
                    if (misaligned) begin
                        state_d       = RESP;
                        rsp_valid_d   = 1'b1;
                        rsp_rdata_d   = '0;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b0;
                    end else begin
                        state_d = SETUP;
                        psel_d  = 1'b1;
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                // A completion in the expiry cycle still counts as a normal completion.
                if (pready) begin
                    state_d       = RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = (req_q.write || pslverr) ? '0 : prdata;
                    rsp_err_d     = pslverr;
                    rsp_timeout_d = 1'b0;
                end else if (wd_expired) begin
                    state_d       = RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            req_q         <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign paddr       = req_q.addr;
    assign pwrite      = req_q.write;
    assign pwdata      = req_q.wdata;
    assign pstrb       = req_q.strb;
    assign pprot       = req_q.prot;

endmodule

// File: doc/apb_requester.md
Name: apb_requester

Overview:
APB4 initiator (requester) that turns a simple valid/ready request channel into single APB transfers. It returns results on a valid/ready response channel. It sits upstream of APB interconnect or delay stages and drives their paddr/psel/penable/… inputs. A per-transfer watchdog aborts transfers whose completer never asserts pready.

Parameters:
- TIMEOUT, 1024, maximum ACCESS-phase cycles before abort; 0 disables the watchdog.
- CHECK_ALIGN, 1, when 1 a request with addr[1:0]!=0 is rejected with an error and no APB transfer is issued.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when high with req_valid
- req_addr  in  32  byte address
- req_write  in  1  1 = write, 0 = read
- req_wdata  in  32  write data
- req_wstrb  in  4  write byte strobes
- req_prot  in  3  protection attributes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  32  read data (0 for writes and errors)
- rsp_err  out  1  pslverr, timeout, or misalignment
- rsp_timeout  out  1  error caused by the watchdog
- paddr  out  32  APB address
- psel  out  1  APB select
- penable  out  1  APB enable
- pprot  out  3  APB protection
- pwrite  out  1  APB direction
- pwdata  out  32  APB write data
- pstrb  out  4  APB strobes (forced 0 on reads)
- pready  in  1  completer ready
- prdata  in  32  completer read data
- pslverr  in  1  completer error

Behaviour:
- States: IDLE, SETUP, ACCESS, RESP.
- Reset (synchronous): state IDLE, watchdog 0. All outputs are 0 except req_ready, which is 1 in IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid, capture addr, write, wdata, wstrb, prot. pstrb capture is wstrb if write, else 4'b0.
  - Aligned request (or CHECK_ALIGN=0) → SETUP.
  - Misaligned request with CHECK_ALIGN=1 → RESP with rsp_err=1, rsp_timeout=0, rsp_rdata=0. No APB activity.
- SETUP: psel=1, penable=0, captured fields driven. Lasts exactly 1 cycle, then ACCESS.
- ACCESS:
  - psel=1, penable=1. paddr/pwrite/pwdata/pstrb/pprot stay constant from SETUP through the final ACCESS cycle.
  - pready=1 → RESP. Register rsp_rdata=prdata for reads (0 for writes), rsp_err=pslverr, rsp_timeout=0.
  - pready=0 and TIMEOUT!=0: watchdog increments. When it has counted TIMEOUT cycles without pready → RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - pready in the same cycle the watchdog would expire: pready wins (normal completion).
- RESP:
  - psel=penable=0. rsp_valid=1, and rsp_* are held stable until rsp_ready.
  - On rsp_ready → IDLE, watchdog cleared.
- req_ready is high only in IDLE. No request is accepted while a response is pending.
- Latency: accept at cycle N, SETUP N+1, first ACCESS N+2. With zero wait states, rsp_valid is at N+3.
- Minimum issue interval: 4 cycles (accept, SETUP, ACCESS, RESP with rsp_ready=1).
- Watchdog width is clog2(TIMEOUT+1) bits, minimum 1. It cannot wrap, because it saturates at expiry.
- Reset mid-transfer: psel and penable drop at the reset edge. The transfer is abandoned and no response is produced.
- Nothing is sampled from the completer outside ACCESS. pready/prdata/pslverr in other states are ignored.
- pwdata and pprot are passed unchanged on reads.

Decomposition:
- Shared package apb_pkg holds:
  - the state enum (IDLE/SETUP/ACCESS/RESP);
  - constants APB_ADDR_W=32, APB_DATA_W=32, APB_STRB_W=4, APB_PROT_W=3;
  - a captured-request struct type.
- One sub-module, apb_watchdog. Inputs: clear, enable. Parameter: TIMEOUT. Output: expired.

Test Plan:
- Zero-wait read: req addr 0x1000_0004, read; completer pready=1 in the first ACCESS cycle with prdata 0xDEADBEEF → rsp_valid at accept+3, rsp_rdata=0xDEADBEEF, rsp_err=0. psel high 2 cycles, penable high 1.
- Waited write: addr 0x20, wdata 0x12345678, wstrb 4'b0110, pready after 5 ACCESS cycles → pstrb=0110 and paddr/pwdata stable all 6 phase cycles; rsp_err=0, rsp_rdata=0.
- Slave error and read strobes: read with req_wstrb=4'hF; completer returns pslverr=1 → pstrb=0 during the transfer, rsp_err=1, rsp_timeout=0.
- Timeout: TIMEOUT=8, pready stuck 0 → exactly 8 ACCESS cycles, then psel=0, rsp_err=1, rsp_timeout=1. Repeat with pready=1 on the 8th cycle → normal completion, rsp_timeout=0.
- Backpressure and misalignment: hold rsp_ready=0 for 10 cycles → rsp_* stable, req_ready=0 throughout. Then addr 0x3 with CHECK_ALIGN=1 → psel never asserted, rsp_err=1 one cycle after accept.
- Reset mid-ACCESS: assert reset during a waited transfer → next cycle psel=penable=rsp_valid=0, req_ready=1. A following request completes normally.
